// File: rtl/mod_pingpong_buffer.sv
// Two-bank symbol buffer between the modulation mapper and the transform precoder:
// the mapper fills one bank while the other streams out over valid/ready.
module mod_pingpong_buffer #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 1200
) (
  input  logic                  CLK_Mod,
  input  logic                  RST_Mod,
  input  logic                  Wr_En,
  input  logic [ADDR_WIDTH-1:0] Wr_Addr,
  input  logic [DATA_WIDTH-1:0] Wr_I,
  input  logic [DATA_WIDTH-1:0] Wr_Q,
  input  logic                  Switch,
  input  logic [ADDR_WIDTH-1:0] Last_Addr,
  input  logic                  Rd_Ready,
  output logic                  Rd_Valid,
  output logic [DATA_WIDTH-1:0] Rd_I,
  output logic [DATA_WIDTH-1:0] Rd_Q,
  output logic [ADDR_WIDTH-1:0] Rd_Index,
  output logic                  Rd_Last,
  output logic                  Wr_Bank,
  output logic [1:0]            Bank_Full,
  output logic                  Overflow
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam int EW = SW + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  // Handshake: a symbol transfers on every clock edge where Rd_Valid and Rd_Ready are both
  // high; while Rd_Valid=1 and Rd_Ready=0 the presented symbol and its index/last flag hold.
  typedef enum logic [1:0] {RD_IDLE, RD_STREAM, RD_RELEASE} rd_state_e;

  rd_state_e             rd_state_q, rd_state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic [ADDR_WIDTH-1:0] len0_q, len0_d, len1_q, len1_d;
  logic                  overflow_q, overflow_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  issue_q, issue_d;
  logic [ADDR_WIDTH-1:0] issue_idx_q, issue_idx_d;
  logic                  issue_last_q, issue_last_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic [EW-1:0]         head_q, head_d, tail_q, tail_d;

  logic [SW-1:0]         mem0 [DEPTH];
  logic [SW-1:0]         mem1 [DEPTH];
  logic [SW-1:0]         ram_rdata_q;

  logic [ADDR_WIDTH-1:0] cur_len, sat_len;
  logic [1:0]            full_rel;
  logic [2:0]            occ;
  logic [EW-1:0]         push_entry;
  logic                  pop, release_now, issue, other_bank;

  always_comb begin
    cur_len      = rd_bank_q ? len1_q : len0_q;
    pop          = (fifo_cnt_q != 2'd0) && Rd_Ready;
    release_now  = pop && head_q[0] && (rd_state_q == RD_STREAM);
    occ          = 3'(fifo_cnt_q) + 3'(issue_q) - 3'(pop);
    issue        = (rd_state_q == RD_STREAM) && (rd_ptr_q < cur_len) && (occ < 3'd2);
    push_entry   = {ram_rdata_q, issue_idx_q, issue_last_q};
    sat_len      = (Last_Addr > DEPTH_A) ? DEPTH_A : Last_Addr;
    other_bank   = ~wr_bank_q;

    // A bank drained on this edge is free again for a Switch on the same edge.
    full_rel = bank_full_q;
    if (release_now) full_rel[rd_bank_q] = 1'b0;

    bank_full_d = full_rel;
    wr_bank_d   = wr_bank_q;
    len0_d      = len0_q;
    len1_d      = len1_q;
    overflow_d  = 1'b0;
    if (Switch && (Last_Addr != '0)) begin
      if (!full_rel[other_bank]) begin
        bank_full_d[wr_bank_q] = 1'b1;
        if (wr_bank_q) len1_d = sat_len;
        else           len0_d = sat_len;
        wr_bank_d = other_bank;
      end else begin
        overflow_d = 1'b1;
      end
    end

    rd_state_d   = rd_state_q;
    rd_bank_d    = rd_bank_q;
    rd_ptr_d     = rd_ptr_q;
    issue_d      = issue;
    issue_idx_d  = rd_ptr_q;
    issue_last_d = (rd_ptr_q == cur_len - 1'b1);
    case (rd_state_q)
      RD_IDLE: begin
        if (|bank_full_q) begin
          rd_bank_d  = bank_full_q[1];
          rd_ptr_d   = '0;
          rd_state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
        if (release_now) rd_state_d = RD_RELEASE;
      end
      default: rd_state_d = RD_IDLE;
    endcase

    // Two-entry skid FIFO: head drives the outputs, tail absorbs the in-flight read.
    head_d     = head_q;
    tail_d     = tail_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({issue_q, pop})
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          head_d = push_entry;
        end else begin
          head_d = tail_q;
          tail_d = push_entry;
        end
      end
      2'b01: begin
        head_d     = tail_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b10: begin
        if (fifo_cnt_q == 2'd0) head_d = push_entry;
        else                    tail_d = push_entry;
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_Mod or negedge RST_Mod) begin
    if (!RST_Mod) begin
      rd_state_q   <= RD_IDLE;
      wr_bank_q    <= 1'b0;
      bank_full_q  <= 2'b00;
      len0_q       <= '0;
      len1_q       <= '0;
      overflow_q   <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_ptr_q     <= '0;
      issue_q      <= 1'b0;
      issue_idx_q  <= '0;
      issue_last_q <= 1'b0;
      fifo_cnt_q   <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
    end else begin
      rd_state_q   <= rd_state_d;
      wr_bank_q    <= wr_bank_d;
      bank_full_q  <= bank_full_d;
      len0_q       <= len0_d;
      len1_q       <= len1_d;
      overflow_q   <= overflow_d;
      rd_bank_q    <= rd_bank_d;
      rd_ptr_q     <= rd_ptr_d;
      issue_q      <= issue_d;
      issue_idx_q  <= issue_idx_d;
      issue_last_q <= issue_last_d;
      fifo_cnt_q   <= fifo_cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
    end
  end

  // Symbol RAM: one write port into the fill bank, one registered read port from the drain bank.
  always_ff @(posedge CLK_Mod) begin
    if (Wr_En && (Wr_Addr < DEPTH_A)) begin
      if (wr_bank_q) mem1[Wr_Addr] <= {Wr_I, Wr_Q};
      else           mem0[Wr_Addr] <= {Wr_I, Wr_Q};
    end
    if (issue) ram_rdata_q <= rd_bank_q ? mem1[rd_ptr_q] : mem0[rd_ptr_q];
  end

  assign Rd_Valid  = (fifo_cnt_q != 2'd0);
  assign Rd_I      = head_q[EW-1 -: DATA_WIDTH];
  assign Rd_Q      = head_q[EW-1-DATA_WIDTH -: DATA_WIDTH];
  assign Rd_Index  = head_q[ADDR_WIDTH:1];
  assign Rd_Last   = head_q[0];
  assign Wr_Bank   = wr_bank_q;
  assign Bank_Full = bank_full_q;
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_mod_pingpong_buffer.sv
// Bench for mod_pingpong_buffer: directed steps plus random banks, checked against a
// bank-level model that expands each accepted Switch into its expected symbol list.
module tb_mod_pingpong_buffer;

  localparam int DW = 18;
  localparam int AW = 11;
  localparam int DEPTH = 1200;

  logic          clk, rst_n;
  logic          wr_en, sw, rd_ready;
  logic [AW-1:0] wr_addr, last_addr;
  logic [DW-1:0] wr_i, wr_q;
  logic          rd_valid, rd_last, wr_bank, overflow;
  logic [DW-1:0] rd_i, rd_q;
  logic [AW-1:0] rd_index;
  logic [1:0]    bank_full;

  mod_pingpong_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .CLK_Mod(clk), .RST_Mod(rst_n),
    .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_I(wr_i), .Wr_Q(wr_q),
    .Switch(sw), .Last_Addr(last_addr), .Rd_Ready(rd_ready),
    .Rd_Valid(rd_valid), .Rd_I(rd_i), .Rd_Q(rd_q), .Rd_Index(rd_index), .Rd_Last(rd_last),
    .Wr_Bank(wr_bank), .Bank_Full(bank_full), .Overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: memory image per bank, expected output queue, banks awaiting drain
  logic [47:0] exp_q[$];
  int          open_banks[$];
  logic [2*DW-1:0] model_mem [2][DEPTH];
  logic        m_wr_bank = 1'b0;
  logic        exp_ovf = 1'b0;
  logic        held = 1'b0;
  logic [47:0] held_val;
  logic [47:0] e;
  logic [1:0]  exp_full;
  int          pops = 0;
  int          blen;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      open_banks.delete();
      m_wr_bank = 1'b0;
      exp_ovf   = 1'b0;
      held      = 1'b0;
    end else begin
      exp_full = (open_banks.size() != 0) ? (2'b01 << open_banks[0]) : 2'b00;
      check("wr_bank", wr_bank, m_wr_bank);
      check("bank_full", bank_full, exp_full);
      check("overflow", overflow, exp_ovf);
      if (held) begin
        check("stall_valid", rd_valid, 1'b1);
        check("stall_hold", {rd_i, rd_q, rd_index, rd_last}, held_val);
      end
      held     = rd_valid && !rd_ready;
      held_val = {rd_i, rd_q, rd_index, rd_last};
      exp_ovf  = 1'b0;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_when_empty", rd_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rd_symbol", {rd_i, rd_q, rd_index, rd_last}, e);
          pops++;
          if (e[0]) void'(open_banks.pop_front());
        end
      end
      if (wr_en && (int'(wr_addr) < DEPTH)) model_mem[m_wr_bank][wr_addr] = {wr_i, wr_q};
      if (sw && (last_addr != '0)) begin
        if (open_banks.size() == 0) begin
          blen = (int'(last_addr) > DEPTH) ? DEPTH : int'(last_addr);
          for (int k = 0; k < blen; k++)
            exp_q.push_back({model_mem[m_wr_bank][k], AW'(k), k == blen - 1});
          open_banks.push_back(int'(m_wr_bank));
          m_wr_bank = ~m_wr_bank;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  end

  // driver tasks: every task starts and ends 1 ns after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sym(input int addr, input logic [DW-1:0] i, input logic [DW-1:0] q);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_i = i; wr_q = q;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_switch(input int last);
    sw = 1'b1; last_addr = AW'(last);
    tick();
    sw = 1'b0; last_addr = '0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    rd_ready = 1'b1;
    for (int n = 0; n < max_cyc && exp_q.size() != 0; n++) tick();
    tick();
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, rd_valid, 1'b0);
    check({tag, "_data"}, {rd_i, rd_q, rd_index, rd_last}, '0);
    check({tag, "_wr_bank"}, wr_bank, 1'b0);
    check({tag, "_bank_full"}, bank_full, 2'b00);
    check({tag, "_overflow"}, overflow, 1'b0);
  endtask

  int base;

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; sw = 1'b0; rd_ready = 1'b0;
    wr_addr = '0; last_addr = '0; wr_i = '0; wr_q = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // short QPSK bank: latency, 12 back-to-back symbols, last flag
    rd_ready = 1'b1;
    for (int k = 0; k < 12; k++) write_sym(k, DW'(724 * k), DW'(724 * k));
    base = pops;
    pulse_switch(12);
    check("lat_n0", rd_valid, 1'b0);
    tick(); check("lat_n1", rd_valid, 1'b0);
    tick(); check("lat_n2", rd_valid, 1'b0);
    tick(); check("lat_n3", rd_valid, 1'b1);
    check("first_index", rd_index, '0);
    for (int k = 1; k < 12; k++) begin
      tick(); check("burst_valid", rd_valid, 1'b1);
    end
    tick(); check("burst_end", rd_valid, 1'b0);
    check("qpsk_pops", pops - base, 12);
    check("qpsk_full_clear", bank_full, 2'b00);
    check("qpsk_wr_bank", wr_bank, 1'b1);

    // full 1200-symbol bank with Rd_Ready toggling every cycle
    rd_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) write_sym(k, DW'($urandom), DW'($urandom));
    pulse_switch(DEPTH);
    for (int n = 0; n < 4000 && exp_q.size() != 0; n++) begin
      rd_ready = ~rd_ready;
      tick();
    end
    drain("full_bank_drained", 10);

    // overflow: bank0 held by stalled reader, bank1 closed too early
    rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) write_sym(k, DW'($urandom), DW'($urandom));
    pulse_switch(5);
    for (int k = 0; k < 7; k++) write_sym(k, DW'($urandom), DW'($urandom));
    pulse_switch(7);
    check("ovf_pulse", overflow, 1'b1);
    check("ovf_wr_bank", wr_bank, 1'b1);
    check("ovf_bank_full", bank_full, 2'b01);
    tick(); check("ovf_one_cycle", overflow, 1'b0);
    drain("ovf_drained", 50);

    // Switch with Last_Addr=0 is ignored
    pulse_switch(0);
    for (int n = 0; n < 5; n++) begin
      check("zero_len_valid", rd_valid, 1'b0);
      check("zero_len_wr_bank", wr_bank, 1'b1);
      tick();
    end

    // write and Switch on the same edge: symbol 3 belongs to the closing bank
    for (int k = 0; k < 3; k++) write_sym(k, DW'($urandom), DW'($urandom));
    wr_en = 1'b1; wr_addr = AW'(3); wr_i = DW'($urandom); wr_q = DW'($urandom);
    sw = 1'b1; last_addr = AW'(4);
    tick();
    wr_en = 1'b0; sw = 1'b0; last_addr = '0;
    write_sym(3, DW'($urandom), DW'($urandom));
    drain("same_edge_drained", 50);

    // reset at symbol 50 of a 100-symbol stream
    for (int k = 0; k < 100; k++) write_sym(k, DW'($urandom), DW'($urandom));
    base = pops;
    pulse_switch(100);
    for (int n = 0; n < 300 && (pops - base) < 50; n++) tick();
    check("reset_point", pops - base, 50);
    rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    tick(); tick();
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick(); check("post_reset_idle", rd_valid, 1'b0);
    end
    for (int k = 0; k < 3; k++) write_sym(k, DW'($urandom), DW'($urandom));
    pulse_switch(3);
    drain("post_reset_drained", 50);

    // random banks with random backpressure, including rejected switches
    for (int b = 0; b < 8; b++) begin
      blen = $urandom_range(1, 40);
      for (int k = 0; k < blen; k++) begin
        rd_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) write_sym($urandom_range(DEPTH, 2047), DW'($urandom), DW'($urandom));
        write_sym(k, DW'($urandom), DW'($urandom));
      end
      pulse_switch(blen);
    end
    drain("random_drained", 400);

    // Last_Addr beyond DEPTH saturates to a full bank
    for (int k = 0; k < DEPTH; k++) write_sym(k, DW'($urandom), DW'($urandom));
    base = pops;
    pulse_switch(2047);
    drain("sat_drained", 1500);
    check("sat_pops", pops - base, DEPTH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
